// File: rtl/out_port_scheduler_if.sv
// out_port_scheduler_if: descriptor-FIFO request side and packet-buffer read side of one output port scheduler.
interface out_port_scheduler_if #(
    parameter int pPORT_NUM   = 4,
    parameter int pLEN_WIDTH  = 8,
    parameter int pPTR_WIDTH  = 8,
    parameter int pFIFO_WIDTH = pLEN_WIDTH + pPTR_WIDTH
);
    logic [pPORT_NUM-1:0]             i_req;
    logic [pPORT_NUM*pFIFO_WIDTH-1:0] i_desc;
    logic [pPORT_NUM-1:0]             o_pop;
    logic [pPORT_NUM-1:0]             o_grant;
    logic                             i_out_ready;
    logic                             o_rd_en;
    logic [pPTR_WIDTH-1:0]            o_rd_addr;
    logic                             o_sop;
    logic                             o_eop;
    logic                             o_err;
    logic                             o_busy;
    modport master (
        input  i_req, i_desc, i_out_ready,
        output o_pop, o_grant, o_rd_en, o_rd_addr, o_sop, o_eop, o_err, o_busy
    );
    modport slave (
        output i_req, i_desc, i_out_ready,
        input  o_pop, o_grant, o_rd_en, o_rd_addr, o_sop, o_eop, o_err, o_busy
    );
endinterface

// File: rtl/out_port_scheduler.sv
// out_port_scheduler: round-robin share of one output port among descriptor FIFOs, then word-by-word
// packet-buffer reads of the winning packet under downstream backpressure.
module out_port_scheduler #(
    parameter int pPORT_NUM   = 4,
    parameter int pLEN_WIDTH  = 8,
    parameter int pPTR_WIDTH  = 8,
    parameter int pFIFO_WIDTH = pLEN_WIDTH + pPTR_WIDTH
) (
    input  logic iclk,
    input  logic irst,
    out_port_scheduler_if.master bus
);
    localparam int SW = $clog2(pPORT_NUM);
    typedef enum logic {IDLE, XFER} state_t;
    state_t                  state, state_nx;
    logic [SW-1:0]           rr_ptr, sel, cur;
    logic [pLEN_WIDTH-1:0]   len, count, dlen;
    logic [pPTR_WIDTH-1:0]   ptr, dptr;
    logic [pFIFO_WIDTH-1:0]  desc;
    logic [pPORT_NUM-1:0]    onehot;
    logic                    found, take, rd_en, last;
    int                      j;
    function automatic logic [SW-1:0] nxt(input logic [SW-1:0] p);
        return p == SW'(pPORT_NUM - 1) ? '0 : p + 1'b1;
    endfunction
    // Descending scan so the requester closest to rr_ptr is the one left in sel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = pPORT_NUM - 1; i >= 0; i--) begin
            j = (int'(rr_ptr) + i) % pPORT_NUM;
            if (bus.i_req[j]) begin
                found = 1'b1;
                sel   = SW'(j);
            end
        end
    end
    assign desc   = bus.i_desc[sel*pFIFO_WIDTH +: pFIFO_WIDTH];
    assign dlen   = desc[pFIFO_WIDTH-1 -: pLEN_WIDTH];
    assign dptr   = desc[pPTR_WIDTH-1:0];
    assign onehot = pPORT_NUM'(1) << sel;
    // No grant while a pop is in flight: the FIFO head still shows the descriptor just taken.
    assign take   = (state == IDLE) && found && (bus.o_pop == '0);
    assign rd_en  = (state == XFER) && bus.i_out_ready;
    assign last   = rd_en && (count == len - pLEN_WIDTH'(1));
    always_comb begin
        state_nx = state;
        state_nx = take && dlen != '0 ? XFER : last ? IDLE : state;
    end
    always_ff @(posedge iclk) begin
        if (irst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur         <= '0;
            len         <= '0;
            ptr         <= '0;
            count       <= '0;
            bus.o_pop   <= '0;
            bus.o_grant <= '0;
            bus.o_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            bus.o_pop <= take ? onehot : '0;
            bus.o_err <= take && dlen == '0;
            if (take) begin
                len         <= dlen;
                ptr         <= dptr;
                cur         <= sel;
                count       <= '0;
                bus.o_grant <= onehot;
                if (dlen == '0) rr_ptr <= nxt(sel);
            end else if (last) begin
                count       <= '0;
                rr_ptr      <= nxt(cur);
                bus.o_grant <= '0;
            end else if (bus.o_err) begin
                bus.o_grant <= '0;
            end else if (rd_en) begin
                count <= count + 1'b1;
            end
        end
    end
    assign bus.o_rd_en   = rd_en;
    assign bus.o_rd_addr = ptr + pPTR_WIDTH'(count);
    assign bus.o_sop     = rd_en && count == '0;
    assign bus.o_eop     = last;
    assign bus.o_busy    = state == XFER;
endmodule

// File: tb/tb_out_port_scheduler.sv
// tb_out_port_scheduler: directed vectors with hand-computed expectations for out_port_scheduler.
module tb_out_port_scheduler;
    logic iclk = 1'b0;
    logic irst;
    int   vecs = 0;
    int   errs = 0;
    always #5 iclk = ~iclk;
    out_port_scheduler_if #(.pPORT_NUM(4), .pLEN_WIDTH(8), .pPTR_WIDTH(8)) bus ();
    out_port_scheduler #(.pPORT_NUM(4), .pLEN_WIDTH(8), .pPTR_WIDTH(8)) dut (
        .iclk(iclk),
        .irst(irst),
        .bus (bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge iclk);
        #1;
    endtask
    task automatic set_desc(input int n, input logic [7:0] l, input logic [7:0] p);
        bus.i_desc[n*16 +: 16] = {l, p};
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, " pop"}, 32'(bus.o_pop), 0);
        chk({tag, " grant"}, 32'(bus.o_grant), 0);
        chk({tag, " rd_en"}, 32'(bus.o_rd_en), 0);
        chk({tag, " busy"}, 32'(bus.o_busy), 0);
    endtask
    task automatic chk_rd(input string tag, input logic [3:0] g, input logic [7:0] a, input logic s, input logic e);
        chk({tag, " grant"}, 32'(bus.o_grant), 32'(g));
        chk({tag, " rd_en"}, 32'(bus.o_rd_en), 1);
        chk({tag, " addr"}, 32'(bus.o_rd_addr), 32'(a));
        chk({tag, " sop"}, 32'(bus.o_sop), 32'(s));
        chk({tag, " eop"}, 32'(bus.o_eop), 32'(e));
    endtask
    initial begin
        irst            = 1'b1;
        bus.i_req       = 4'b1111;
        bus.i_out_ready = 1'b1;
        bus.i_desc      = '0;
        for (int n = 0; n < 4; n++) set_desc(n, 8'd1, 8'(n * 16));
        // Reset: everything quiet, and nothing popped in the first cycle after release.
        cyc();
        chk_idle("rst1");
        chk("rst1 addr", 32'(bus.o_rd_addr), 0);
        chk("rst1 err", 32'(bus.o_err), 0);
        cyc();
        chk_idle("rst2");
        irst = 1'b0;
        #1;
        chk_idle("rel");
        // Round robin, all len=1: grants 0,1,2,3,0, one every two cycles.
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr pop", 32'(bus.o_pop), 32'(4'b0001 << (k % 4)));
            chk_rd("rr", 4'b0001 << (k % 4), 8'((k % 4) * 16), 1'b1, 1'b1);
            cyc();
            chk_idle("rr gap");
        end
        bus.i_req = 4'b0000;
        // Port 2 only, len=3, ptr=0x10.
        cyc();
        set_desc(2, 8'd3, 8'h10);
        bus.i_req = 4'b0100;
        cyc();
        bus.i_req = 4'b0000;
        #1;
        chk("p2 pop", 32'(bus.o_pop), 32'b0100);
        chk_rd("p2 r0", 4'b0100, 8'h10, 1'b1, 1'b0);
        chk("p2 busy", 32'(bus.o_busy), 1);
        cyc();
        chk("p2 pop off", 32'(bus.o_pop), 0);
        chk_rd("p2 r1", 4'b0100, 8'h11, 1'b0, 1'b0);
        cyc();
        chk_rd("p2 r2", 4'b0100, 8'h12, 1'b0, 1'b1);
        cyc();
        chk_idle("p2 done");
        // Backpressure: port 0 (wraps from rr_ptr=3), len=4, ptr=0x20, ready 1,0,1,0,1,0,1.
        set_desc(0, 8'd4, 8'h20);
        bus.i_req = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            cyc();
            bus.i_req       = 4'b0000;
            bus.i_out_ready = (k % 2 == 0);
            #1;
            chk("bp grant", 32'(bus.o_grant), 1);
            chk("bp rd_en", 32'(bus.o_rd_en), 32'(k % 2 == 0));
            chk("bp addr", 32'(bus.o_rd_addr), 32'(8'h20 + 8'((k + 1) / 2)));
            chk("bp sop", 32'(bus.o_sop), 32'(k == 0));
            chk("bp eop", 32'(bus.o_eop), 32'(k == 6));
        end
        bus.i_out_ready = 1'b1;
        cyc();
        chk_idle("bp done");
        // Address wrap on port 1: 0xFE, 0xFF, 0x00.
        set_desc(1, 8'd3, 8'hFE);
        bus.i_req = 4'b0010;
        cyc();
        bus.i_req = 4'b0000;
        #1;
        chk_rd("wr r0", 4'b0010, 8'hFE, 1'b1, 1'b0);
        cyc();
        chk_rd("wr r1", 4'b0010, 8'hFF, 1'b0, 1'b0);
        cyc();
        chk_rd("wr r2", 4'b0010, 8'h00, 1'b0, 1'b1);
        cyc();
        // Zero-length on port 1 (rr_ptr=2 wraps to 1): pop and err together, no reads.
        set_desc(1, 8'd0, 8'h55);
        bus.i_req = 4'b0010;
        cyc();
        bus.i_req = 4'b0000;
        #1;
        chk("z pop", 32'(bus.o_pop), 32'b0010);
        chk("z err", 32'(bus.o_err), 1);
        chk("z grant", 32'(bus.o_grant), 32'b0010);
        chk("z rd_en", 32'(bus.o_rd_en), 0);
        chk("z busy", 32'(bus.o_busy), 0);
        cyc();
        chk_idle("z after");
        chk("z err off", 32'(bus.o_err), 0);
        // rr_ptr must now be 2: with ports 1 and 2 requesting, port 2 wins.
        set_desc(2, 8'd1, 8'h40);
        bus.i_req = 4'b0110;
        cyc();
        bus.i_req = 4'b0000;
        #1;
        chk_rd("rr2", 4'b0100, 8'h40, 1'b1, 1'b1);
        cyc();
        chk_idle("rr2 done");
        // Reset mid-packet: port 0, len=8, ptr=0x80, reset after the third read.
        set_desc(0, 8'd8, 8'h80);
        bus.i_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.i_req = 4'b0000;
            #1;
            chk_rd("mr", 4'b0001, 8'h80 + 8'(k), k == 0, 1'b0);
        end
        cyc();
        irst = 1'b1;
        cyc();
        irst = 1'b0;
        #1;
        chk_idle("mr rst");
        set_desc(0, 8'd1, 8'h33);
        bus.i_req = 4'b1111;
        cyc();
        bus.i_req = 4'b0000;
        #1;
        chk("mr pop", 32'(bus.o_pop), 1);
        chk_rd("mr fresh", 4'b0001, 8'h33, 1'b1, 1'b1);
        cyc();
        chk_idle("mr done");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
